// File: rtl/xp_port_vc_tx.sv
// rtl/xp_port_vc_tx.sv - multi-VC credit-checked router port transmitter with round-robin arbitration
// Optional: define XP_PORT_ESCAPE_VC_EN to make VC0 a strict-priority deadlock-escape channel.
module xp_port_vc_tx #(
    parameter int NUM_VC   = 4,
    parameter int FLIT_W   = 128,
    parameter int VC_DEPTH = 4,
    parameter int VC_ID_W  = $clog2(NUM_VC),
    parameter int CREDIT_W = $clog2(VC_DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_VC-1:0]          in_valid,
    output logic [NUM_VC-1:0]          in_ready,
    input  logic [NUM_VC*FLIT_W-1:0]   in_flit,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [FLIT_W-1:0]          out_flit,
    output logic [VC_ID_W-1:0]         out_vc_id,
    input  logic                       crd_rtn_valid,
    input  logic [VC_ID_W-1:0]         crd_rtn_vc,
    output logic [NUM_VC*CREDIT_W-1:0] credit_count,
    output logic                       crd_err
);

`ifdef XP_PORT_ESCAPE_VC_EN
    localparam bit ESC_EN = 1'b1;
`else
    localparam bit ESC_EN = 1'b0;
`endif

    logic [CREDIT_W-1:0] r_credit [NUM_VC];
    logic                r_out_valid;
    logic [FLIT_W-1:0]   r_out_flit;
    logic [VC_ID_W-1:0]  r_out_vc_id;
    logic [VC_ID_W-1:0]  r_rr_ptr;
    logic                r_crd_err;

    logic                w_slot_free;
    logic [NUM_VC-1:0]   w_eligible;
    logic [NUM_VC-1:0]   w_grant;
    logic                w_grant_any;
    logic [VC_ID_W-1:0]  w_grant_vc;
    logic [NUM_VC-1:0]   w_rtn_hit;
    logic [NUM_VC-1:0]   w_full;
    logic                w_rtn_bad;
    logic                w_ovf;

    assign w_slot_free = !r_out_valid || out_ready;
    assign w_rtn_bad   = crd_rtn_valid && (int'(crd_rtn_vc) >= NUM_VC);

    always_comb begin
        w_eligible = '0;
        w_rtn_hit  = '0;
        w_full     = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            w_eligible[v] = !rst && in_valid[v] && (r_credit[v] != '0) && w_slot_free;
            w_rtn_hit[v]  = crd_rtn_valid && !w_rtn_bad && (crd_rtn_vc == VC_ID_W'(v));
            w_full[v]     = (r_credit[v] == CREDIT_W'(VC_DEPTH));
        end
    end

    // Escape mode: VC0 preempts, and the rotating search skips it.
    always_comb begin
        int idx;
        idx         = 0;
        w_grant_any = 1'b0;
        w_grant_vc  = '0;
        if (ESC_EN && w_eligible[0]) begin
            w_grant_any = 1'b1;
        end
        for (int i = 0; i < NUM_VC; i++) begin
            idx = (int'(r_rr_ptr) + i) % NUM_VC;
            if (!w_grant_any && w_eligible[idx] && !(ESC_EN && idx == 0)) begin
                w_grant_any = 1'b1;
                w_grant_vc  = VC_ID_W'(idx);
            end
        end
        w_grant = w_grant_any ? (NUM_VC'(1) << w_grant_vc) : '0;
    end

    assign w_ovf = |(w_rtn_hit & ~w_grant & w_full);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_flit  <= '0;
            r_out_vc_id <= '0;
            r_rr_ptr    <= '0;
            r_crd_err   <= 1'b0;
            for (int v = 0; v < NUM_VC; v++) r_credit[v] <= CREDIT_W'(VC_DEPTH);
        end else begin
            if (w_slot_free) begin
                r_out_valid <= w_grant_any;
                if (w_grant_any) begin
                    r_out_flit  <= in_flit[w_grant_vc*FLIT_W +: FLIT_W];
                    r_out_vc_id <= w_grant_vc;
                end
            end
            if (w_grant_any && !(ESC_EN && w_grant_vc == '0)) begin
                r_rr_ptr <= (w_grant_vc == VC_ID_W'(NUM_VC - 1)) ? '0 : w_grant_vc + 1'b1;
            end
            for (int v = 0; v < NUM_VC; v++) begin
                if (w_rtn_hit[v] && !w_grant[v] && !w_full[v]) r_credit[v] <= r_credit[v] + 1'b1;
                else if (w_grant[v] && !w_rtn_hit[v])           r_credit[v] <= r_credit[v] - 1'b1;
            end
            if (w_ovf || w_rtn_bad) r_crd_err <= 1'b1;
        end
    end

    always_comb begin
        credit_count = '0;
        for (int v = 0; v < NUM_VC; v++) credit_count[v*CREDIT_W +: CREDIT_W] = r_credit[v];
    end

    assign in_ready  = w_grant;
    assign out_valid = r_out_valid;
    assign out_flit  = r_out_flit;
    assign out_vc_id = r_out_vc_id;
    assign crd_err   = r_crd_err;

endmodule
